o_scope_timer_master: RTL and testbench

//  Avalon-MM initiator that owns and services the o-scope interval timer slave (16-bit data, 3-bit word address).

---
 rtl/o_scope_timer_master.sv | 157 +++++++++++++++
 tb/tb_o_scope_timer_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/o_scope_timer_master.sv
// Avalon-MM initiator for the o-scope interval timer: programs the period, runs the timer, clears timeouts, emits ticks.
// O_SCOPE_TMR_READBACK_EN adds a status readback (RD_CAP) after each clear that catches timeouts racing the clear.
module o_scope_timer_master #(
  parameter logic [31:0] PERIOD_DEFAULT = 32'd33329,
  parameter bit          CONTINUOUS     = 1'b1,
  parameter int          TICK_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           period,
  input  logic                  period_load,
  output logic [2:0]            m_address,
  output logic                  m_chipselect,
  output logic                  m_write_n,
  output logic [15:0]           m_writedata,
  input  logic [15:0]           m_readdata,
  input  logic                  irq,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  running,
  output logic                  busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_PL    = 4'd1;
  localparam logic [3:0] S_WR_PH    = 4'd2;
  localparam logic [3:0] S_WR_CTRL  = 4'd3;
  localparam logic [3:0] S_WAIT_IRQ = 4'd4;
  localparam logic [3:0] S_CLR      = 4'd5;
  localparam logic [3:0] S_SETTLE   = 4'd6;
  localparam logic [3:0] S_WR_STOP  = 4'd7;
`ifdef O_SCOPE_TMR_READBACK_EN
  localparam logic [3:0] S_RD_CAP   = 4'd8;
`endif

  // Control word bits: [3] STOP, [2] START, [1] CONT, [0] ITO.
  localparam logic [15:0] CTRL_START = {12'b0, 1'b0, 1'b1, CONTINUOUS, 1'b1};
  localparam logic [15:0] CTRL_STOP  = {12'b0, 1'b1, 1'b0, CONTINUOUS, 1'b1};
  localparam logic [TICK_CNT_W-1:0] CNT_ONE = TICK_CNT_W'(1);

  logic [3:0]  state, next_state;
  logic [31:0] shadow, shadow_nxt;
  logic        pend_stop, pend_load;
  logic        in_busy_state;

  logic        cs_nxt, wn_nxt;
  logic [2:0]  addr_nxt;
  logic [15:0] wd_nxt;

  // Bus data uses the post-load shadow so a load coinciding with start writes one consistent period.
  always_comb begin
    shadow_nxt = shadow;
    if (period_load) shadow_nxt = (period == 32'd0) ? 32'd1 : period;
  end

  assign in_busy_state = (state != S_IDLE) && (state != S_WAIT_IRQ);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start && !stop) next_state = S_WR_PL;
      S_WR_PL:    next_state = S_WR_PH;
      S_WR_PH:    next_state = S_WR_CTRL;
      S_WR_CTRL:  next_state = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (pend_stop || stop)             next_state = S_WR_STOP;
        else if (pend_load || period_load) next_state = S_WR_PL;
        else if (irq)                      next_state = S_CLR;
      end
      S_CLR:      next_state = S_SETTLE;
`ifdef O_SCOPE_TMR_READBACK_EN
      S_SETTLE:   next_state = S_RD_CAP;
      S_RD_CAP: begin
        if (m_readdata[0])   next_state = S_CLR;
        else if (CONTINUOUS) next_state = S_WAIT_IRQ;
        else                 next_state = S_IDLE;
      end
`else
      S_SETTLE:   next_state = CONTINUOUS ? S_WAIT_IRQ : S_IDLE;
`endif
      S_WR_STOP:  next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the state being entered so they register alongside it.
  always_comb begin
    cs_nxt   = 1'b0;
    wn_nxt   = 1'b1;
    addr_nxt = 3'd0;
    wd_nxt   = 16'h0000;
    case (next_state)
      S_WR_PL:   begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = 3'd2; wd_nxt = shadow_nxt[15:0];  end
      S_WR_PH:   begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = 3'd3; wd_nxt = shadow_nxt[31:16]; end
      S_WR_CTRL: begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = 3'd1; wd_nxt = CTRL_START;        end
      S_CLR:     begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = 3'd0; wd_nxt = 16'h0000;          end
      S_SETTLE:  begin cs_nxt = 1'b1; wn_nxt = 1'b1; addr_nxt = 3'd0; end
`ifdef O_SCOPE_TMR_READBACK_EN
      S_RD_CAP:  begin cs_nxt = 1'b1; wn_nxt = 1'b1; addr_nxt = 3'd0; end
`endif
      S_WR_STOP: begin cs_nxt = 1'b1; wn_nxt = 1'b0; addr_nxt = 3'd1; wd_nxt = CTRL_STOP;         end
      default:   begin cs_nxt = 1'b0; end
    endcase
  end

`ifdef O_SCOPE_TMR_READBACK_EN
  logic unused_rd;
  assign unused_rd = ^m_readdata[15:2];
`else
  logic unused_rd;
  assign unused_rd = ^m_readdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      shadow       <= PERIOD_DEFAULT;
      pend_stop    <= 1'b0;
      pend_load    <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= 3'd0;
      m_writedata  <= 16'h0000;
      tick         <= 1'b0;
      tick_count   <= '0;
      running      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= next_state;
      shadow       <= shadow_nxt;
      m_chipselect <= cs_nxt;
      m_write_n    <= wn_nxt;
      m_address    <= addr_nxt;
      m_writedata  <= wd_nxt;
      tick         <= (next_state == S_CLR);
      busy         <= (next_state != S_IDLE) && (next_state != S_WAIT_IRQ);
      if (next_state == S_CLR) tick_count <= tick_count + CNT_ONE;

      // Requests seen mid-sequence are parked until the next WAIT_IRQ; returning to IDLE drops them.
      if (next_state == S_IDLE)          pend_stop <= 1'b0;
      else if (stop && in_busy_state)    pend_stop <= 1'b1;

      if (next_state == S_IDLE)                                 pend_load <= 1'b0;
      else if (state == S_WAIT_IRQ && next_state == S_WR_PL)    pend_load <= 1'b0;
      else if (period_load && in_busy_state)                    pend_load <= 1'b1;

      if (next_state == S_WR_CTRL)                                running <= 1'b1;
      else if (next_state == S_WR_STOP || next_state == S_IDLE)   running <= 1'b0;
`ifdef O_SCOPE_TMR_READBACK_EN
      else if (state == S_RD_CAP)                                 running <= m_readdata[1];
`endif
    end
  end

endmodule

// File: tb/tb_o_scope_timer_master.sv
// Directed bench for o_scope_timer_master: continuous instance (4-bit tick counter) and a one-shot instance.
module tb_o_scope_timer_master;

  logic        clk;
  logic        reset_n;
  logic        start, stop, period_load, irq, irq_os;
  logic [31:0] period;
  logic [15:0] m_readdata;

  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n, tick, running, busy;
  logic [15:0] m_writedata;
  logic [3:0]  tick_count;

  logic [2:0]  os_m_address;
  logic        os_m_chipselect, os_m_write_n, os_tick, os_running, os_busy;
  logic [15:0] os_m_writedata;
  logic [15:0] os_tick_count;

  int n_assert = 0;
  int n_fail   = 0;
  int tick_seen = 0;

  o_scope_timer_master #(.TICK_CNT_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .period(period),
    .period_load(period_load), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata), .irq(irq),
    .tick(tick), .tick_count(tick_count), .running(running), .busy(busy)
  );

  o_scope_timer_master #(.CONTINUOUS(1'b0)) u_os (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .period(period),
    .period_load(period_load), .m_address(os_m_address), .m_chipselect(os_m_chipselect),
    .m_write_n(os_m_write_n), .m_writedata(os_m_writedata), .m_readdata(m_readdata), .irq(irq_os),
    .tick(os_tick), .tick_count(os_tick_count), .running(os_running), .busy(os_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    if (tick) tick_seen++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] addr, input logic [15:0] data);
    chk({tag, "_cs"},   {31'b0, m_chipselect}, 32'd1);
    chk({tag, "_wn"},   {31'b0, m_write_n},    32'd0);
    chk({tag, "_addr"}, {29'b0, m_address},    {29'b0, addr});
    chk({tag, "_data"}, {16'b0, m_writedata},  {16'b0, data});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs"},   {31'b0, m_chipselect}, 32'd0);
    chk({tag, "_wn"},   {31'b0, m_write_n},    32'd1);
    chk({tag, "_addr"}, {29'b0, m_address},    32'd0);
    chk({tag, "_wd"},   {16'b0, m_writedata},  32'd0);
    chk({tag, "_tick"}, {31'b0, tick},         32'd0);
    chk({tag, "_cnt"},  {28'b0, tick_count},   32'd0);
    chk({tag, "_run"},  {31'b0, running},      32'd0);
    chk({tag, "_busy"}, {31'b0, busy},         32'd0);
  endtask

  // One timeout: irq held until one cycle after the clear write, as the timer slave does.
  task automatic service(input string tag, input logic [3:0] exp_cnt);
    irq = 1'b1;
    step();
    chk_wr({tag, "_clr"}, 3'd0, 16'h0000);
    chk({tag, "_tick"}, {31'b0, tick}, 32'd1);
    chk({tag, "_cnt"}, {28'b0, tick_count}, {28'b0, exp_cnt});
    step();
    chk({tag, "_settle_cs"}, {31'b0, m_chipselect}, 32'd1);
    chk({tag, "_settle_wn"}, {31'b0, m_write_n}, 32'd1);
    chk({tag, "_settle_tick"}, {31'b0, tick}, 32'd0);
    irq = 1'b0;
`ifdef O_SCOPE_TMR_READBACK_EN
    step();
    chk({tag, "_rdcap_cs"}, {31'b0, m_chipselect}, 32'd1);
    chk({tag, "_rdcap_wn"}, {31'b0, m_write_n}, 32'd1);
`endif
    step();
    chk({tag, "_wait_cs"}, {31'b0, m_chipselect}, 32'd0);
    chk({tag, "_wait_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_wait_run"}, {31'b0, running}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; period = 32'd0; period_load = 1'b0;
    irq = 1'b0; irq_os = 1'b0; m_readdata = 16'h0002;
    step(); step();
    chk_reset("rst");
    reset_n = 1'b1;
    step();

    // Default period 33329 = 0x8231 programmed on three consecutive cycles.
    start = 1'b1;
    step();
    start = 1'b0;
    chk_wr("t1_pl", 3'd2, 16'h8231);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    step();
    chk_wr("t1_ph", 3'd3, 16'h0000);
    step();
    chk_wr("t1_ctrl", 3'd1, 16'h0007);
    chk("t1_run", {31'b0, running}, 32'd1);
    step();
    chk("t1_wait_cs", {31'b0, m_chipselect}, 32'd0);
    chk("t1_wait_busy", {31'b0, busy}, 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_wr("t1_stop", 3'd1, 16'h000B);
    chk("t1_stop_run", {31'b0, running}, 32'd0);
    step();
    chk("t1_idle_busy", {31'b0, busy}, 32'd0);

    // start together with stop in IDLE: stop wins, nothing happens.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", {31'b0, busy}, 32'd0);
    chk("ss_cs", {31'b0, m_chipselect}, 32'd0);

    // period_load in IDLE updates the shadow only.
    period = 32'h0001_0004; period_load = 1'b1;
    step();
    period_load = 1'b0;
    chk("t2_load_cs", {31'b0, m_chipselect}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_wr("t2_pl", 3'd2, 16'h0004);
    step();
    chk_wr("t2_ph", 3'd3, 16'h0001);
    step();
    chk_wr("t2_ctrl", 3'd1, 16'h0007);
    repeat (32'h10004 + 1) step();
    chk("t2_no_early_tick", tick_seen, 32'd0);
    service("t2", 4'd1);
    chk("t2_ticks", tick_seen, 32'd1);

    // 1000 timeouts on a fresh run; the 4-bit counter wraps to 1000 mod 16.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("t3_rst_cnt", {28'b0, tick_count}, 32'd0);
    tick_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 1000; i++) begin
      irq = 1'b1;
      step();
      step();
      irq = 1'b0;
`ifdef O_SCOPE_TMR_READBACK_EN
      step();
`endif
      step();
    end
    chk("t3_ticks", tick_seen, 32'd1000);
    chk("t3_cnt", {28'b0, tick_count}, 32'd8);
    chk("t3_run", {31'b0, running}, 32'd1);

    // period_load during CLR is parked and replayed as a reprogram; period 0 clamps to 1.
    irq = 1'b1;
    step();
    chk("t4_tick", {31'b0, tick}, 32'd1);
    chk("t4_cnt", {28'b0, tick_count}, 32'd9);
    period = 32'd0; period_load = 1'b1;
    step();
    period_load = 1'b0; irq = 1'b0;
`ifdef O_SCOPE_TMR_READBACK_EN
    step();
`endif
    step();
    chk("t4_wait_cs", {31'b0, m_chipselect}, 32'd0);
    step();
    chk_wr("t4_pl", 3'd2, 16'h0001);
    chk("t4_run_pl", {31'b0, running}, 32'd1);
    step();
    chk_wr("t4_ph", 3'd3, 16'h0000);
    step();
    chk_wr("t4_ctrl", 3'd1, 16'h0007);
    step();
    chk("t4_run", {31'b0, running}, 32'd1);
    chk("t4_busy", {31'b0, busy}, 32'd0);

    // stop and irq together in WAIT_IRQ: stop wins, no tick.
    tick_seen = 0;
    stop = 1'b1; irq = 1'b1;
    step();
    stop = 1'b0; irq = 1'b0;
    chk_wr("t5_stop", 3'd1, 16'h000B);
    chk("t5_tick", {31'b0, tick}, 32'd0);
    chk("t5_run", {31'b0, running}, 32'd0);
    step();
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_cnt", {28'b0, tick_count}, 32'd9);
    chk("t5_ticks", tick_seen, 32'd0);

    // One-shot instance: control word has CONT=0, ends in IDLE after one tick.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("os_ctrl_data", {16'b0, os_m_writedata}, 32'h0005);
    chk("os_ctrl_addr", {29'b0, os_m_address}, 32'd1);
    step();
    irq_os = 1'b1;
    step();
    chk("os_tick", {31'b0, os_tick}, 32'd1);
    chk("os_cnt", {16'b0, os_tick_count}, 32'd1);
    step();
    irq_os = 1'b0;
`ifdef O_SCOPE_TMR_READBACK_EN
    step();
`endif
    step();
    chk("os_busy", {31'b0, os_busy}, 32'd0);
    chk("os_run", {31'b0, os_running}, 32'd0);
    chk("os_cs", {31'b0, os_m_chipselect}, 32'd0);
    irq_os = 1'b1;
    step();
    irq_os = 1'b0;
    chk("os_idle_no_tick", {31'b0, os_tick}, 32'd0);

`ifdef O_SCOPE_TMR_READBACK_EN
    // Status still shows TO after the clear: a second CLR and tick follow.
    irq = 1'b1;
    step();
    chk("t6_cnt1", {28'b0, tick_count}, 32'd1);
    step();
    irq = 1'b0;
    m_readdata = 16'h0003;
    step();
    step();
    m_readdata = 16'h0002;
    chk_wr("t6_clr2", 3'd0, 16'h0000);
    chk("t6_tick2", {31'b0, tick}, 32'd1);
    chk("t6_cnt2", {28'b0, tick_count}, 32'd2);
    step(); step(); step();
    chk("t6_run", {31'b0, running}, 32'd1);
    chk("t6_busy", {31'b0, busy}, 32'd0);
`endif

    // Reset in the middle of the period programming sequence.
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    chk("t7_idle", {31'b0, busy}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_wr("t7_ph", 3'd3, 16'h0000);
    reset_n = 1'b0;
    step();
    chk_reset("t7_rst");
    reset_n = 1'b1;
    step();
    chk("t7_after_busy", {31'b0, busy}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_wr("t7_restart_pl", 3'd2, 16'h8231);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
